// File: rtl/aes_round_sequencer.sv
// Control FSM for an iterative AES datapath: key load, initial AddRoundKey, NUM_ROUNDS rounds paced by key latency.
// Latency: block accepted at T -> DONE at T+2+NUM_ROUNDS*(KEY_LAT+1); out_valid holds until out_ready.
module aes_round_sequencer #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_LAT    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_load_req,
    output logic       chg_key,
    input  logic       change_key_done,
    input  logic       blk_valid,
    output logic       blk_ready,
    output logic [3:0] cur_round,
    output logic       round_en,
    output logic       first_round,
    output logic       last_round,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       key_valid,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_KEY,
        S_INIT,
        S_KEY_WAIT,
        S_ROUND,
        S_DONE
    } state_e;

    localparam logic [3:0] LAST_RND  = 4'(NUM_ROUNDS);
    localparam logic [2:0] WAIT_INIT = 3'(KEY_LAT - 1);

    state_e     state_q;
    logic [3:0] round_q;
    logic [2:0] wait_q;
    logic       key_valid_q;
    logic       kreq_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            round_q     <= 4'd0;
            wait_q      <= 3'd0;
            key_valid_q <= 1'b0;
            kreq_pend_q <= 1'b0;
        end else begin
            // A key request seen mid-block is remembered and served once back in IDLE.
            if (key_load_req && state_q != S_IDLE && state_q != S_LOAD_KEY) begin
                kreq_pend_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    round_q <= 4'd0;
                    if (key_load_req || kreq_pend_q) begin
                        state_q     <= S_LOAD_KEY;
                        key_valid_q <= 1'b0;
                        kreq_pend_q <= 1'b0;
                    end else if (blk_valid && key_valid_q) begin
                        state_q <= S_INIT;
                    end
                end
                S_LOAD_KEY: begin
                    if (change_key_done) begin
                        state_q     <= S_IDLE;
                        key_valid_q <= 1'b1;
                    end
                end
                S_INIT: begin
                    state_q <= S_KEY_WAIT;
                    round_q <= 4'd1;
                    wait_q  <= WAIT_INIT;
                end
                S_KEY_WAIT: begin
                    if (wait_q == 3'd0) begin
                        state_q <= S_ROUND;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                S_ROUND: begin
                    if (round_q == LAST_RND) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_KEY_WAIT;
                        round_q <= round_q + 4'd1;
                        wait_q  <= WAIT_INIT;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                        round_q <= 4'd0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign chg_key     = (state_q == S_LOAD_KEY);
    assign blk_ready   = (state_q == S_IDLE) && key_valid_q && !key_load_req && !kreq_pend_q;
    assign cur_round   = round_q;
    assign round_en    = (state_q == S_INIT) || (state_q == S_ROUND);
    assign first_round = (state_q == S_INIT);
    assign last_round  = (state_q == S_ROUND) && (round_q == LAST_RND);
    assign out_valid   = (state_q == S_DONE);
    assign key_valid   = key_valid_q;
    assign busy        = (state_q != S_IDLE);

endmodule

// File: doc/aes_round_sequencer.md
AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning the number of cipher rounds after the initial AddRoundKey (legal range 1..14).
REQ-002 SHALL have parameter KEY_LAT, default 1, meaning the cycles from a cur_round change to a valid round key (legal range 1..7).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-005 SHALL have port key_load_req, input, 1: request to load a new cipher key into the key generator.
REQ-006 SHALL have port chg_key, output, 1: key-load strobe to the round-key generator.
REQ-007 SHALL have port change_key_done, input, 1: key generator has captured the new key.
REQ-008 SHALL have port blk_valid, input, 1: a data block is offered.
REQ-009 SHALL have port blk_ready, output, 1: the sequencer accepts the block this cycle.
REQ-010 SHALL have port cur_round, output, 4: round index driven to the key generator.
REQ-011 SHALL have port round_en, output, 1: the datapath applies one round this cycle.
REQ-012 SHALL have port first_round, output, 1: the current round_en is the initial AddRoundKey, using the original key.
REQ-013 SHALL have port last_round, output, 1: the current round_en is the final round, which skips MixColumns.
REQ-014 SHALL have port out_valid, output, 1: the result block is ready.
REQ-015 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-016 SHALL have port key_valid, output, 1: a key has been loaded since reset.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-018 SHALL implement the states IDLE, LOAD_KEY, INIT, KEY_WAIT, ROUND and DONE as a registered FSM; all outputs are decoded from registered state and counters.
REQ-019 SHALL drive blk_ready=1 only in IDLE when key_valid=1 and key_load_req=0; a block is accepted on the cycle where blk_valid and blk_ready are both 1.
REQ-020 SHALL give key_load_req priority in IDLE: key_load_req=1 moves the FSM IDLE->LOAD_KEY, clears key_valid on entry, and leaves blk_ready=0.
REQ-021 SHALL hold chg_key=1 and cur_round=0 throughout LOAD_KEY; when change_key_done=1 is sampled, chg_key drops, key_valid becomes 1 on the next cycle, and the FSM returns to IDLE.
REQ-022 SHALL defer a key_load_req raised in INIT, KEY_WAIT, ROUND or DONE; the request is acted on only after the FSM has returned to IDLE, and key_valid stays 1 for the block in flight.
REQ-023 SHALL move to INIT on the cycle after a block is accepted (T); in INIT, cur_round=0 and round_en=first_round=1 for exactly one cycle.
REQ-024 SHALL, for each r in 1..NUM_ROUNDS:
- set cur_round=r;
- spend exactly KEY_LAT cycles in KEY_WAIT with round_en=0;
- then spend one cycle in ROUND with round_en=1.
REQ-025 SHALL assert last_round=1 only in the ROUND cycle with r=NUM_ROUNDS; first_round and last_round are 0 at all other times.
REQ-026 SHALL place ROUND for round r at cycle T+1+r*(KEY_LAT+1); the FSM enters DONE at cycle T+2+NUM_ROUNDS*(KEY_LAT+1), which is T+22 for the default parameters.
REQ-027 SHALL hold out_valid=1 in DONE until out_ready=1 is sampled, then return to IDLE on the next cycle; out_ready is ignored outside DONE.
REQ-028 SHALL hold cur_round stable during KEY_WAIT and ROUND, and hold cur_round=NUM_ROUNDS in DONE; the round counter never wraps past NUM_ROUNDS.
REQ-029 SHALL ignore blk_valid outside IDLE, and ignore change_key_done outside LOAD_KEY.
REQ-030 SHALL, when key_load_req=1 and out_ready=1 arrive together in DONE, complete the output handshake first and enter LOAD_KEY from IDLE on the following cycle.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, set state=IDLE, clear the round and wait counters, drive chg_key, blk_ready, round_en, first_round, last_round, out_valid, key_valid and busy to 0, and drive cur_round=0.
REQ-032 SHALL, when rst=1 arrives mid-operation, abandon any block or key load in progress, with no out_valid pulse; after reset, key_valid=0, so a key must be reloaded before any block is accepted.

Verification
REQ-033 SHALL cover key load: with key_load_req=1 and change_key_done asserted 3 cycles later -> chg_key high for 3 cycles, key_valid=1 one cycle after done, blk_ready=1 in IDLE.
REQ-034 SHALL cover the default encryption: block accepted at T -> round_en at T+1 (cur_round=0, first_round=1), then at T+3, T+5, ..., T+21 (cur_round=1..10), last_round only at T+21, out_valid at T+22.
REQ-035 SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> out_valid held 1 and blk_ready=0 throughout; out_ready=1 -> IDLE next cycle.
REQ-036 SHALL cover a deferred key load: key_load_req raised at T+8 of an encryption -> rounds complete unchanged, then LOAD_KEY entered after DONE, with no block accepted in between.
REQ-037 SHALL cover reset mid-round: rst=1 at T+10 -> all outputs 0 next cycle, no out_valid, and blk_valid ignored until a new key is loaded.
REQ-038 SHALL cover parameter variation: with KEY_LAT=2 and NUM_ROUNDS=14 -> round_en spacing of 3 cycles and DONE at T+44.
